// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch push-button front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned CLOCK_HZ = 32'd50_000_000;

  localparam int unsigned KEY_START_STOP = 32'd0;
  localparam int unsigned KEY_LAP_RESET  = 32'd1;

  // 20 ms debounce window and 1 s long-press threshold at CLOCK_HZ.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 32'd1_000_000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 32'd50_000_000;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce/hold FSM and registered event pulses.
module key_channel
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic clock_50M,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              meta_q;
  logic              key_sync_q;
  key_state_t        state_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              long_fired_q;
  logic              key_level_q;
  logic              press_q;
  logic              release_q;
  logic              short_q;
  logic              long_q;

  logic [DEB_W-1:0]  deb_inc_d;
  logic              deb_done_d;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              long_hit_d;

  always_comb begin
    deb_inc_d  = deb_cnt_q + 1'b1;
    deb_done_d = (deb_cnt_q >= DEB_LAST);
    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 1'b1;
    long_hit_d = (hold_cnt_q == HOLD_LAST) && !long_fired_q;
  end

  // deb_cnt holds the number of consecutive opposing samples already seen, so
  // the sample that leaves a settled state counts as the first one.
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      meta_q       <= 1'b1;
      key_sync_q   <= 1'b1;
      state_q      <= IDLE;
      deb_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      key_level_q  <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      meta_q     <= key_n;
      key_sync_q <= meta_q;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      case (state_q)
        IDLE, PRESS_WAIT: begin
          if (key_sync_q) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
          end else if (deb_done_d) begin
            state_q      <= HELD;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            key_level_q  <= 1'b1;
            press_q      <= 1'b1;
          end else begin
            state_q   <= PRESS_WAIT;
            deb_cnt_q <= deb_inc_d;
          end
        end
        HELD, RELEASE_WAIT: begin
          hold_cnt_q <= hold_cnt_d;
          if (long_hit_d) begin
            long_q       <= 1'b1;
            long_fired_q <= 1'b1;
          end
          if (!key_sync_q) begin
            state_q   <= HELD;
            deb_cnt_q <= '0;
          end else if (deb_done_d) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            key_level_q <= 1'b0;
            release_q   <= 1'b1;
            short_q     <= !long_fired_q && !long_hit_d;
          end else begin
            state_q   <= RELEASE_WAIT;
            deb_cnt_q <= deb_inc_d;
          end
        end
        default: begin
          state_q     <= IDLE;
          deb_cnt_q   <= '0;
          key_level_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounced key front end: NUM_KEYS independent key_channel instances.
module key_conditioner
  import stopwatch_pkg::*;
#(
  parameter int          NUM_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic                clock_50M,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] short_pulse,
  output logic [NUM_KEYS-1:0] long_pulse
);

  if (NUM_KEYS < 1) begin : g_bad_num_keys
    $error("key_conditioner: NUM_KEYS must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("key_conditioner: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_key_channel (
      .clock_50M    (clock_50M),
      .reset        (reset),
      .key_n        (key_n[k]),
      .key_level    (key_level[k]),
      .press_pulse  (press_pulse[k]),
      .release_pulse(release_pulse[k]),
      .short_pulse  (short_pulse[k]),
      .long_pulse   (long_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomized bench for key_conditioner against a run-length debounce model.
module tb_key_conditioner;

  localparam int NK = 2;
  localparam int DEB = 4;
  localparam int LONGC = 20;

  logic          clock_50M = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = 2'b11;
  logic [NK-1:0] key_level, press_pulse, release_pulse, short_pulse, long_pulse;

  key_conditioner #(
    .NUM_KEYS         (NK),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONGC)
  ) dut (
    .clock_50M    (clock_50M),
    .reset        (reset),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clock_50M = ~clock_50M;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Model: raw key seen two samples late, level flips after DEB equal samples.
  logic [1:0]    seen_hist [NK];
  logic [NK-1:0] m_level, m_press, m_release, m_short, m_long;
  int            m_run [NK];
  int            m_age [NK];
  bit            m_fired [NK];
  int            model_longs = 0;
  int            dut_longs = 0;
  int            cyc = 0;

  task automatic check_eq(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    logic s;
    m_press = '0; m_release = '0; m_short = '0; m_long = '0;
    for (int k = 0; k < NK; k++) begin
      if (reset) begin
        seen_hist[k] = 2'b11;
        m_level[k] = 1'b0;
        m_run[k] = 0;
        m_age[k] = 0;
        m_fired[k] = 1'b0;
      end else begin
        s = seen_hist[k][1];
        seen_hist[k] = {seen_hist[k][0], key_n[k]};
        if (m_level[k] == 1'b0) begin
          m_run[k] = (s == 1'b0) ? m_run[k] + 1 : 0;
          if (m_run[k] == DEB) begin
            m_level[k] = 1'b1; m_press[k] = 1'b1;
            m_run[k] = 0; m_age[k] = 0; m_fired[k] = 1'b0;
          end
        end else begin
          if (m_age[k] < LONGC) m_age[k]++;
          if (m_age[k] == LONGC && !m_fired[k]) begin
            m_long[k] = 1'b1; m_fired[k] = 1'b1; model_longs++;
          end
          m_run[k] = (s == 1'b1) ? m_run[k] + 1 : 0;
          if (m_run[k] == DEB) begin
            m_level[k] = 1'b0; m_release[k] = 1'b1;
            m_short[k] = !m_fired[k]; m_run[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic [NK-1:0] kn);
    reset = rst;
    key_n = kn;
    @(posedge clock_50M);
    model_step();
    cyc++;
    @(negedge clock_50M);
    for (int k = 0; k < NK; k++) if (long_pulse[k] === 1'b1) dut_longs++;
    check_eq("key_level", key_level, m_level);
    check_eq("press_pulse", press_pulse, m_press);
    check_eq("release_pulse", release_pulse, m_release);
    check_eq("short_pulse", short_pulse, m_short);
    check_eq("long_pulse", long_pulse, m_long);
  endtask

  int   left [NK];
  logic [NK-1:0] cur;
  int   rst_left;

  initial begin
    for (int k = 0; k < NK; k++) begin
      seen_hist[k] = 2'b11; m_run[k] = 0; m_age[k] = 0; m_fired[k] = 1'b0;
    end
    m_level = '0;
    @(negedge clock_50M);
    // Reset with keys released, then with both keys held through reset.
    repeat (3) cycle(1'b1, 2'b11);
    repeat (3) cycle(1'b0, 2'b11);
    repeat (3) cycle(1'b1, 2'b00);
    repeat (12) cycle(1'b0, 2'b00);
    repeat (10) cycle(1'b0, 2'b11);
    // Press bounce on key 0, then a clean press.
    repeat (3) cycle(1'b0, 2'b10);
    cycle(1'b0, 2'b11);
    repeat (3) cycle(1'b0, 2'b10);
    repeat (4) cycle(1'b0, 2'b11);
    repeat (8) cycle(1'b0, 2'b10);
    // Short release with two cycles of bounce.
    repeat (2) cycle(1'b0, 2'b11);
    cycle(1'b0, 2'b10);
    repeat (10) cycle(1'b0, 2'b11);
    // Simultaneous press; key 1 released early, key 0 held into long press.
    repeat (8) cycle(1'b0, 2'b00);
    repeat (30) cycle(1'b0, 2'b10);
    repeat (10) cycle(1'b0, 2'b11);
    // Random per-key dwell times mixing glitches and long holds, plus resets.
    cur = 2'b11;
    rst_left = 0;
    for (int k = 0; k < NK; k++) left[k] = $urandom_range(1, 30);
    repeat (4000) begin
      for (int k = 0; k < NK; k++) begin
        if (left[k] == 0) begin
          cur[k] = ~cur[k];
          left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 35);
        end
        left[k]--;
      end
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      cycle(rst_left != 0, cur);
      if (rst_left != 0) rst_left--;
    end
    checks_cnt++;
    if (dut_longs != model_longs) begin
      errors_cnt++;
      $display("FAIL long_count: got %0d expected %0d", dut_longs, model_longs);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
